// File: rtl/vmm_pkg.sv
// Shared constants and types for the VMM input serializer.
// Holds the channel-order encodings, default geometry and the stream state type.
package vmm_pkg;

    localparam int unsigned ORD_CH0_FIRST  = 0;
    localparam int unsigned ORD_CHN_FIRST  = 1;

    localparam int unsigned DEFAULT_DATA_W = 10;
    localparam int unsigned DEFAULT_N_CH   = 4;

    typedef enum logic {
        StIdle,
        StStream
    } vmm_state_e;

    // Channel counter width; never below one bit so the counter stays a real signal.
    function automatic int unsigned vmm_cnt_w(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/vmm_word_mux.sv
// Selects one channel word out of a packed frame.
// The index counts transfer order; ORDER decides which end of the frame goes first.
module vmm_word_mux
    import vmm_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned N_CH   = DEFAULT_N_CH,
    parameter int unsigned ORDER  = ORD_CHN_FIRST,
    parameter int unsigned IDX_W  = vmm_cnt_w(N_CH)
) (
    input  logic [N_CH*DATA_W-1:0] frame_i,
    input  logic [IDX_W-1:0]       index_i,
    output logic [DATA_W-1:0]      word_o
);

    logic [IDX_W-1:0] sel;

    always_comb begin
        if (ORDER == ORD_CHN_FIRST) begin
            sel = IDX_W'(N_CH - 1) - index_i;
        end else begin
            sel = index_i;
        end

        word_o = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (sel == IDX_W'(c)) begin
                word_o = frame_i[c*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/vmm_input_serializer.sv
// Serializes N_CH-word frames into a valid/ready word stream.
// One active frame streams out while a second frame may wait in a holding register.
module vmm_input_serializer
    import vmm_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned N_CH   = DEFAULT_N_CH,
    parameter int unsigned ORDER  = ORD_CHN_FIRST
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [N_CH*DATA_W-1:0] din,
    input  logic                   load_valid,
    output logic                   load_ready,
    output logic [DATA_W-1:0]      dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   dout_last,
    output logic                   busy
);

    localparam int unsigned      CNT_W   = vmm_cnt_w(N_CH);
    localparam int unsigned      FRAME_W = N_CH * DATA_W;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_CH - 1);

    vmm_state_e         state_q, state_d;
    logic [FRAME_W-1:0] active_q, active_d;
    logic [FRAME_W-1:0] hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               xfer;
    logic               at_last;
    logic               freeing;
    logic               accept;
    logic [DATA_W-1:0]  mux_word;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            active_q    <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign dout_valid = (state_q == StStream);
    assign xfer       = dout_valid && dout_ready;
    assign at_last    = (cnt_q == LastCnt);
    assign freeing    = !dout_valid || (xfer && at_last);
    assign accept     = load_valid && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;

        if (xfer) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (freeing) begin
            if (hold_full_q) begin
                // Held frame takes over; a same-cycle accept refills the hold slot.
                active_d    = hold_q;
                cnt_d       = '0;
                state_d     = StStream;
                if (accept) begin
                    hold_d = din;
                end else begin
                    hold_full_d = 1'b0;
                end
            end else if (accept) begin
                active_d = din;
                cnt_d    = '0;
                state_d  = StStream;
            end else begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        end else if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end
    end

    vmm_word_mux #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH),
        .ORDER  (ORDER),
        .IDX_W  (CNT_W)
    ) u_word_mux (
        .frame_i (active_q),
        .index_i (cnt_q),
        .word_o  (mux_word)
    );

    assign dout       = dout_valid ? mux_word : '0;
    assign dout_last  = dout_valid && at_last;
    assign load_ready = !hold_full_q;
    assign busy       = dout_valid || hold_full_q;

endmodule

// File: tb/tb_vmm_input_serializer.sv
// Directed bench for vmm_input_serializer: a per-cycle vector table on an ORDER=1 instance
// and a hand-written back-to-back frame sequence on an ORDER=0 instance.
module tb_vmm_input_serializer;

    localparam int unsigned DW = 10;
    localparam int unsigned NC = 4;
    localparam int unsigned FW = DW * NC;

    typedef struct {
        logic          rst;
        logic          lv;
        logic [FW-1:0] din;
        logic          dr;
        logic          ev;
        logic [DW-1:0] ed;
        logic          el;
        logic          elr;
        logic          eb;
    } vec_t;

    logic          clk;
    logic          rst;

    logic [FW-1:0] din1;
    logic          lv1, lr1, dv1, dr1, dl1, busy1;
    logic [DW-1:0] dout1;

    logic [FW-1:0] din0;
    logic          lv0, lr0, dv0, dr0, dl0, busy0;
    logic [DW-1:0] dout0;

    int tests;
    int fails;

    vmm_input_serializer #(.DATA_W(DW), .N_CH(NC), .ORDER(1)) dut1 (
        .CLK        (clk),
        .Reset      (rst),
        .din        (din1),
        .load_valid (lv1),
        .load_ready (lr1),
        .dout       (dout1),
        .dout_valid (dv1),
        .dout_ready (dr1),
        .dout_last  (dl1),
        .busy       (busy1)
    );

    vmm_input_serializer #(.DATA_W(DW), .N_CH(NC), .ORDER(0)) dut0 (
        .CLK        (clk),
        .Reset      (rst),
        .din        (din0),
        .load_valid (lv0),
        .load_ready (lr0),
        .dout       (dout0),
        .dout_valid (dv0),
        .dout_ready (dr0),
        .dout_last  (dl0),
        .busy       (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t idle(input logic r, input logic lv, input logic [FW-1:0] d,
                                  input logic dr);
        vec_t v;
        v = '{rst: r, lv: lv, din: d, dr: dr, ev: 1'b0, ed: '0, el: 1'b0, elr: 1'b1, eb: 1'b0};
        return v;
    endfunction

    function automatic vec_t word(input logic lv, input logic [FW-1:0] d, input logic dr,
                                  input logic [DW-1:0] w, input logic last, input logic lr);
        vec_t v;
        v = '{rst: 1'b0, lv: lv, din: d, dr: dr, ev: 1'b1, ed: w, el: last, elr: lr, eb: 1'b1};
        return v;
    endfunction

    logic [FW-1:0] fa, fb, fc, fd;
    vec_t          tbl[$];
    logic [DW-1:0] exp_w [8];
    logic          exp_lr[8];

    initial begin
        tests = 0;
        fails = 0;
        fa = {10'h3FF, 10'h003, 10'h002, 10'h001};
        fb = {10'h013, 10'h012, 10'h011, 10'h010};
        fc = {10'h044, 10'h033, 10'h022, 10'h011};
        fd = {10'h155, 10'h2AA, 10'h155, 10'h2AA};

        // Single frame, highest channel first, then idle.
        tbl.push_back(idle(0, 0, '0, 1));
        tbl.push_back(idle(0, 1, fa, 1));
        tbl.push_back(word(0, '0, 1, 10'h3FF, 0, 1));
        tbl.push_back(word(0, '0, 1, 10'h003, 0, 1));
        tbl.push_back(word(0, '0, 1, 10'h002, 0, 1));
        tbl.push_back(word(0, '0, 1, 10'h001, 1, 1));
        tbl.push_back(idle(0, 0, '0, 1));
        // Downstream stall on the second word.
        tbl.push_back(idle(0, 1, fa, 1));
        tbl.push_back(word(0, '0, 1, 10'h3FF, 0, 1));
        tbl.push_back(word(0, '0, 0, 10'h003, 0, 1));
        tbl.push_back(word(0, '0, 0, 10'h003, 0, 1));
        tbl.push_back(word(0, '0, 0, 10'h003, 0, 1));
        tbl.push_back(word(0, '0, 1, 10'h003, 0, 1));
        tbl.push_back(word(0, '0, 1, 10'h002, 0, 1));
        tbl.push_back(word(0, '0, 1, 10'h001, 1, 1));
        tbl.push_back(idle(0, 0, '0, 1));
        // Active and hold full: frame D must be ignored, C streams with no gap.
        tbl.push_back(idle(0, 1, fa, 0));
        tbl.push_back(word(1, fc, 0, 10'h3FF, 0, 1));
        tbl.push_back(word(1, fd, 0, 10'h3FF, 0, 0));
        tbl.push_back(word(1, fd, 1, 10'h3FF, 0, 0));
        tbl.push_back(word(1, fd, 1, 10'h003, 0, 0));
        tbl.push_back(word(1, fd, 1, 10'h002, 0, 0));
        tbl.push_back(word(1, fd, 1, 10'h001, 1, 0));
        tbl.push_back(word(0, '0, 1, 10'h044, 0, 1));
        tbl.push_back(word(0, '0, 1, 10'h033, 0, 1));
        tbl.push_back(word(0, '0, 1, 10'h022, 0, 1));
        tbl.push_back(word(0, '0, 1, 10'h011, 1, 1));
        tbl.push_back(idle(0, 0, '0, 1));
        // Reset mid-frame with hold full, then restart.
        tbl.push_back(idle(0, 1, fa, 1));
        tbl.push_back(word(1, fc, 1, 10'h3FF, 0, 1));
        tbl.push_back(word(0, '0, 1, 10'h003, 0, 0));
        tbl.push_back(idle(1, 0, '0, 1));
        tbl.push_back(idle(0, 1, fa, 1));
        tbl.push_back(word(0, '0, 1, 10'h3FF, 0, 1));
        tbl.push_back(word(0, '0, 1, 10'h003, 0, 1));
        tbl.push_back(word(0, '0, 1, 10'h002, 0, 1));
        tbl.push_back(word(0, '0, 1, 10'h001, 1, 1));
        tbl.push_back(idle(0, 0, '0, 1));

        rst  = 1'b1;
        lv1  = 1'b0;
        din1 = '0;
        dr1  = 1'b1;
        lv0  = 1'b0;
        din0 = '0;
        dr0  = 1'b1;

        // Reset state of both instances, load_valid offered while in reset.
        @(negedge clk);
        lv1  = 1'b1;
        din1 = fa;
        @(negedge clk);
        #1;
        chk("rst.dout_valid", 32'(dv1), 32'd0);
        chk("rst.dout", 32'(dout1), 32'd0);
        chk("rst.dout_last", 32'(dl1), 32'd0);
        chk("rst.busy", 32'(busy1), 32'd0);
        chk("rst.load_ready", 32'(lr1), 32'd1);
        chk("rst0.dout_valid", 32'(dv0), 32'd0);
        chk("rst0.busy", 32'(busy0), 32'd0);
        chk("rst0.load_ready", 32'(lr0), 32'd1);
        @(negedge clk);
        lv1  = 1'b0;
        din1 = '0;
        rst  = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst  = tbl[i].rst;
            lv1  = tbl[i].lv;
            din1 = tbl[i].din;
            dr1  = tbl[i].dr;
            #1;
            chk($sformatf("v%0d.dout_valid", i), 32'(dv1), 32'(tbl[i].ev));
            chk($sformatf("v%0d.dout", i), 32'(dout1), 32'(tbl[i].ed));
            chk($sformatf("v%0d.dout_last", i), 32'(dl1), 32'(tbl[i].el));
            chk($sformatf("v%0d.load_ready", i), 32'(lr1), 32'(tbl[i].elr));
            chk($sformatf("v%0d.busy", i), 32'(busy1), 32'(tbl[i].eb));
        end

        // Channel-0-first: frame B offered one cycle after A, streams with no gap.
        exp_w  = '{10'h001, 10'h002, 10'h003, 10'h3FF, 10'h010, 10'h011, 10'h012, 10'h013};
        exp_lr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        lv0  = 1'b1;
        din0 = fa;
        #1;
        chk("b2b.pre_valid", 32'(dv0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lv0  = (i == 0);
            din0 = (i == 0) ? fb : '0;
            #1;
            chk($sformatf("b2b%0d.dout_valid", i), 32'(dv0), 32'd1);
            chk($sformatf("b2b%0d.dout", i), 32'(dout0), 32'(exp_w[i]));
            chk($sformatf("b2b%0d.dout_last", i), 32'(dl0), 32'((i == 3) || (i == 7)));
            chk($sformatf("b2b%0d.load_ready", i), 32'(lr0), 32'(exp_lr[i]));
        end
        @(negedge clk);
        lv0 = 1'b0;
        #1;
        chk("b2b.end_valid", 32'(dv0), 32'd0);
        chk("b2b.end_dout", 32'(dout0), 32'd0);
        chk("b2b.end_busy", 32'(busy0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vmm_input_serializer.md
VMM_INPUT_SERIALIZER -- requirements
Module: vmm_input_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 10, width of one channel word.
REQ-002 The block SHALL have parameter N_CH, default 4, channels per frame; legal range 2..64.
REQ-003 The block SHALL have parameter ORDER, default 1; 1 = highest channel first, 0 = channel 0 first.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 Reset  input  1  reset; asynchronous, active-high.
REQ-006 din  input  N_CH*DATA_W  frame; channel c at bits [c*DATA_W +: DATA_W].
REQ-007 load_valid  input  1  din holds a frame offered for capture.
REQ-008 load_ready  output  1  block can accept a frame this cycle.
REQ-009 dout  output  DATA_W  current serial word.
REQ-010 dout_valid  output  1  dout carries a valid word.
REQ-011 dout_ready  input  1  downstream accepts dout this cycle.
REQ-012 dout_last  output  1  dout is the final word of its frame.
REQ-013 busy  output  1  a frame is active or held.

Function
REQ-014 Frame accept SHALL occur on a rising edge where load_valid=1 and load_ready=1; din is sampled on that edge.
REQ-015 Storage SHALL be one active frame register plus one holding register (hold_full flag).
REQ-016 load_ready SHALL equal !hold_full (combinational).
REQ-017 Word transfer SHALL occur on an edge where dout_valid=1 and dout_ready=1; a channel counter cnt (clog2(N_CH) bits) advances by 1 per transfer.
REQ-018 The active slot is freeing in a cycle when it is idle or when the transfer at cnt=N_CH-1 occurs.
REQ-019 If the slot is freeing and hold_full=1, hold SHALL move to active and cnt SHALL clear to 0; a same-cycle accept SHALL refill hold, otherwise hold_full clears.
REQ-020 If the slot is freeing, hold_full=0 and an accept occurs, din SHALL load directly into active with cnt=0; latency from accept edge to dout_valid=1 is one edge.
REQ-021 If the slot is freeing and no frame is available, the block SHALL go idle (dout_valid=0).
REQ-022 If the slot is not freeing, an accept SHALL load hold only.
REQ-023 For ORDER=1, dout SHALL be channel N_CH-1-cnt; for ORDER=0, dout SHALL be channel cnt.
REQ-024 dout_last SHALL be 1 exactly when dout_valid=1 and cnt=N_CH-1.
REQ-025 With dout_valid=1 and dout_ready=0, dout, dout_last and cnt SHALL hold unchanged.
REQ-026 dout SHALL be 0 whenever dout_valid=0.
REQ-027 Back-to-back frames with hold pre-filled SHALL stream with no idle cycle between the last word of one frame and the first word of the next.
REQ-028 busy SHALL equal dout_valid OR hold_full.

Reset
REQ-029 While Reset=1, active, hold, cnt, hold_full and dout_valid SHALL be 0, giving dout=0, dout_last=0, busy=0 and load_ready=1.
REQ-030 Reset asserted mid-frame SHALL discard both the active and held frames; the first accept after release starts a new frame at cnt=0.

Structure
REQ-031 Shared package vmm_pkg SHALL hold ORDER encodings (ORD_CH0_FIRST=0, ORD_CHN_FIRST=1) and the default DATA_W/N_CH constants.
REQ-032 Channel selection SHALL be a sub-module vmm_word_mux (frame, index, ORDER in; word out); all state SHALL remain in vmm_input_serializer.

Verification (DATA_W=10, N_CH=4; frame A: ch0..ch3 = 0x001, 0x002, 0x003, 0x3FF)
REQ-033 ORDER=1, dout_ready=1, accept A while idle -> dout = 0x3FF, 0x003, 0x002, 0x001 on 4 consecutive cycles; dout_last on 0x001 only; then dout_valid=0 and dout=0.
REQ-034 ORDER=0, accept A followed by frame B (ch0..ch3 = 0x010..0x013) one cycle later -> dout = 0x001, 0x002, 0x003, 0x3FF, 0x010, 0x011, 0x012, 0x013 with no gap; load_ready=0 from the cycle after B is accepted until A's last word transfers.
REQ-035 dout_ready=0 for 3 cycles after the second word -> dout stays 0x003 (ORDER=1) and dout_last=0 throughout; the sequence resumes unchanged.
REQ-036 Active and hold both full, load_valid=1 -> load_ready=0 and din changes are ignored until the active frame's last word transfers.
REQ-037 Reset pulsed after the second word of A with hold full -> dout_valid=0, busy=0 and load_ready=1 immediately; the next accept of A restarts at 0x3FF.
